mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one pipelined 8x8 multiplier between two independent requesters (A, B), e.g. the manual-entry path and the auto-increment path of the multiplier display.
- Arbitrates round-robin, issues at most one operand pair per cycle, and tracks each operation's owner through the multiplier pipeline with a tag shift register.
- Returns each 16-bit product to its owner with a one-cycle valid pulse. Sits between the top-level control FSM and the pipelined multiplier. Runs on the multiplier's clock.

Parameters:
- LATENCY, 4, cycles from mul_x/mul_y change to the matching mul_ans; legal range 1..8.
- RESET_PRIO_A, 1, 1 = requester A wins the first simultaneous request after reset; 0 = B wins.

Ports:
- clk  in  1  multiplier/scheduler clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A has a valid operand pair; held until granted.
- x_a  in  8  A operand x.
- y_a  in  8  A operand y.
- gnt_a  out  1  combinational; A's operands are accepted this cycle.
- vld_a  out  1  registered one-cycle pulse; ans_a updated this cycle.
- ans_a  out  16  last product returned to A; holds between pulses.
- req_b, x_b, y_b, gnt_b, vld_b, ans_b: same as A for requester B.
- mul_x  out  8  registered operand to multiplier.
- mul_y  out  8  registered operand to multiplier.
- mul_ans  in  16  multiplier product.
- busy  out  1  registered; 1 while any operation is in flight.

Behaviour:
- Reset (async, rst=1): mul_x, mul_y, ans_a, ans_b = 0; vld_a, vld_b, busy = 0; all tag-pipe valid bits cleared.
  - Priority pointer set so the first tie goes to A if RESET_PRIO_A=1, else to B.
  - gnt_a/gnt_b forced 0 while rst=1.
- Arbitration (combinational, each cycle):
  - Only req_a: gnt_a=1.
  - Only req_b: gnt_b=1.
  - Both: grant the requester that did not win the last tie or single grant. The pointer flips to the other side after every grant.
  - Neither: no grant; pointer unchanged.
  - gnt_a and gnt_b are never both 1.
- Issue: on the edge ending a grant cycle n, mul_x/mul_y load the granted operands. A tag {valid=1, owner} enters the tag pipe.
  - Cycles with no grant leave mul_x/mul_y unchanged and insert valid=0.
- Tag pipe: LATENCY+1 stages of {valid, owner}, shifted every cycle.
  - A tag for a grant in cycle n aligns with mul_ans in cycle n+1+LATENCY.
  - On the next edge, the owner's ans register loads mul_ans and its vld pulses.
  - The result is visible in cycle n+2+LATENCY, i.e. total latency LATENCY+2 cycles from gnt.
  - The other requester's ans and vld are unaffected.
- Throughput: one issue per cycle; back-to-back grants to the same requester are legal. Results return strictly in grant order.
- Requester rule: the requester samples gnt in the same cycle. After a grant it either drops req or presents new operands. Operands are only sampled in the grant cycle.
- busy = OR of all tag-pipe valid bits (registered view). It falls in the cycle after the last vld pulse.
- Arithmetic: ans is 16 bits and is not range-checked; 255*255 = 65025 (16'hFE01) must pass intact.
- Reset mid-operation: all in-flight tags are discarded, no vld pulse follows, and the pointer is reinitialised. Products still emerging from the multiplier are ignored.
- No backpressure on results: vld is a pulse, and the requester must capture it or lose it.

Test Plan:
- Reset: hold rst=1 with req_a=req_b=1 -> gnt_a=gnt_b=0, all outputs 0; after release, first grant goes to A (RESET_PRIO_A=1).
- Single op: LATENCY=4, req_a with x_a=12, y_a=13 in cycle 0 only -> gnt_a in cycle 0; mul_x=12, mul_y=13 from cycle 1; vld_a pulses in cycle 6 with ans_a=156; ans_b stays 0; busy 1 in cycles 1..6, 0 from cycle 7.
- Contention: req_a and req_b both held high for cycles 0..3 (A: 3*4, then 5*6; B: 7*8, then 9*10) -> grants A,B,A,B in cycles 0..3; vld_a in cycles 6 and 8 (12, 30); vld_b in cycles 7 and 9 (56, 90).
- Back-to-back max: A only, cycles 0..2, operands 255*255, 1*1, 0*200 -> gnt_a in cycles 0..2; vld_a in cycles 6..8 with ans_a = 65025, 1, 0.
- Alternation without starvation: A granted in cycle 0, then only req_b in cycle 1 -> gnt_b in cycle 1 with no idle cycle; in cycle 2 both requesting -> A granted.
- Reset mid-flight: grants in cycles 0 and 1, rst pulsed in cycle 3 -> no vld_a or vld_b in any later cycle; busy=0 from reset; ans_a=ans_b=0.

Source files
------------

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_arbiter
//  Description : Round-robin sharing of one pipelined 8x8 multiplier between
//                two requesters, with a tag pipe that routes each product
//                back to the requester that issued it.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_arbiter #(
   parameter int LATENCY      = 4,
   parameter bit RESET_PRIO_A = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [7:0]  x_a,
   input  logic [7:0]  y_a,
   output logic        gnt_a,
   output logic        vld_a,
   output logic [15:0] ans_a,
   input  logic        req_b,
   input  logic [7:0]  x_b,
   input  logic [7:0]  y_b,
   output logic        gnt_b,
   output logic        vld_b,
   output logic [15:0] ans_b,
   output logic [7:0]  mul_x,
   output logic [7:0]  mul_y,
   input  logic [15:0] mul_ans,
   output logic        busy
);

   // One stage per multiplier cycle plus one for the registered operand.
   localparam int STAGES = LATENCY + 1;

   logic              prio_a;   // 1: A wins the next tie
   logic [STAGES-1:0] tag_vld;  // operation in flight at this stage
   logic [STAGES-1:0] tag_own;  // 1: owned by A, 0: owned by B
   logic              issue;
   logic              ret_a;
   logic              ret_b;

   // Arbitration: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      gnt_a = !rst && req_a && (!req_b || prio_a);
      gnt_b = !rst && req_b && (!req_a || !prio_a);
      issue = gnt_a || gnt_b;
      ret_a = tag_vld[LATENCY] && tag_own[LATENCY];
      ret_b = tag_vld[LATENCY] && !tag_own[LATENCY];
   end

   // Operand issue, pointer update and owner tracking through the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_x   <= 8'd0;
         mul_y   <= 8'd0;
         prio_a  <= RESET_PRIO_A;
         tag_vld <= '0;
         tag_own <= '0;
      end else begin
         if (gnt_a) begin
            mul_x  <= x_a;
            mul_y  <= y_a;
            prio_a <= 1'b0;
         end else if (gnt_b) begin
            mul_x  <= x_b;
            mul_y  <= y_b;
            prio_a <= 1'b1;
         end
         tag_vld <= {tag_vld[STAGES-2:0], issue};
         tag_own <= {tag_own[STAGES-2:0], gnt_a};
      end
   end

   // Result return: capture the product for its owner and pulse its valid.
   // busy covers everything about to be in the pipe plus the pending pulse,
   // so it drops the cycle after the last valid pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ans_a <= 16'd0;
         ans_b <= 16'd0;
         vld_a <= 1'b0;
         vld_b <= 1'b0;
         busy  <= 1'b0;
      end else begin
         vld_a <= ret_a;
         vld_b <= ret_b;
         if (ret_a) ans_a <= mul_ans;
         if (ret_b) ans_b <= mul_ans;
         busy <= issue || (|tag_vld);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_arbiter
//  Description : Randomized bench for mul_arbiter against a queue-based model
//                of grants, result order and result timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_arbiter;

   localparam int LATENCY      = 4;
   localparam bit RESET_PRIO_A = 1'b1;
   localparam int NCYC         = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b;
   logic [7:0]  x_a, y_a, x_b, y_b;
   logic        gnt_a, gnt_b, vld_a, vld_b, busy;
   logic [15:0] ans_a, ans_b, mul_ans;
   logic [7:0]  mul_x, mul_y;

   mul_arbiter #(.LATENCY(LATENCY), .RESET_PRIO_A(RESET_PRIO_A)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .x_a(x_a), .y_a(y_a), .gnt_a(gnt_a), .vld_a(vld_a), .ans_a(ans_a),
      .req_b(req_b), .x_b(x_b), .y_b(y_b), .gnt_b(gnt_b), .vld_b(vld_b), .ans_b(ans_b),
      .mul_x(mul_x), .mul_y(mul_y), .mul_ans(mul_ans), .busy(busy)
   );

   always #5 clk = ~clk;

   // External pipelined multiplier: product appears LATENCY cycles after operands.
   logic [15:0] hist [LATENCY];
   always @(posedge clk) begin
      hist[0] <= mul_x * mul_y;
      for (int k = 1; k < LATENCY; k++) hist[k] <= hist[k-1];
   end
   assign mul_ans = hist[LATENCY-1];

   typedef struct {
      bit          own_a;
      int          due;
      logic [15:0] prod;
   } op_t;

   op_t         q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [7:0] rand_op();
      int r;
      r = $urandom_range(0, 7);
      if (r < 2) return 8'd255;
      if (r == 2) return 8'd0;
      return 8'($urandom);
   endfunction

   initial begin
      bit          pend_a, pend_b, do_rst, force_both, last_a;
      bit          e_ga, e_gb, e_va, e_vb, e_busy;
      logic [7:0]  oxa, oya, oxb, oyb, e_mx, e_my;
      logic [15:0] e_aa, e_ab;
      op_t         op;

      rst = 1'b1;
      req_a = 0; req_b = 0; x_a = 0; y_a = 0; x_b = 0; y_b = 0;
      pend_a = 0; pend_b = 0;
      oxa = 0; oya = 0; oxb = 0; oyb = 0;
      last_a = !RESET_PRIO_A;
      e_mx = 0; e_my = 0; e_aa = 0; e_ab = 0;

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         do_rst     = (cyc < 2) || (cyc == 700) || ($urandom_range(0, 299) == 0);
         force_both = (cyc < 3) || (cyc == 701);
         rst = do_rst;

         if (!pend_a && (force_both || $urandom_range(0, 3) != 0)) begin
            pend_a = 1; oxa = rand_op(); oya = rand_op();
         end
         if (!pend_b && (force_both || $urandom_range(0, 2) != 0)) begin
            pend_b = 1; oxb = rand_op(); oyb = rand_op();
         end
         req_a = pend_a;
         req_b = pend_b;
         x_a = pend_a ? oxa : 8'($urandom);
         y_a = pend_a ? oya : 8'($urandom);
         x_b = pend_b ? oxb : 8'($urandom);
         y_b = pend_b ? oyb : 8'($urandom);
         #1;

         // Reference expectations for this cycle.
         if (do_rst) begin
            q.delete();
            e_aa = 0; e_ab = 0; e_mx = 0; e_my = 0;
            last_a = !RESET_PRIO_A;
         end
         e_ga = 0; e_gb = 0; e_va = 0; e_vb = 0;
         e_busy = !do_rst && (q.size() > 0);
         if (!do_rst) begin
            if (pend_a && pend_b) begin
               e_ga = !last_a;
               e_gb = last_a;
            end else begin
               e_ga = pend_a;
               e_gb = pend_b;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
               op = q.pop_front();
               if (op.own_a) begin e_va = 1; e_aa = op.prod; end
               else          begin e_vb = 1; e_ab = op.prod; end
            end
         end

         check("gnt_a", 32'(gnt_a), 32'(e_ga));
         check("gnt_b", 32'(gnt_b), 32'(e_gb));
         check("vld_a", 32'(vld_a), 32'(e_va));
         check("vld_b", 32'(vld_b), 32'(e_vb));
         check("ans_a", 32'(ans_a), 32'(e_aa));
         check("ans_b", 32'(ans_b), 32'(e_ab));
         check("busy",  32'(busy),  32'(e_busy));
         check("mul_x", 32'(mul_x), 32'(e_mx));
         check("mul_y", 32'(mul_y), 32'(e_my));

         // Advance the model past this cycle's grant.
         if (e_ga) begin
            op.own_a = 1; op.due = cyc + LATENCY + 2; op.prod = 16'(oxa) * 16'(oya);
            q.push_back(op);
            e_mx = oxa; e_my = oya; last_a = 1; pend_a = 0;
         end else if (e_gb) begin
            op.own_a = 0; op.due = cyc + LATENCY + 2; op.prod = 16'(oxb) * 16'(oyb);
            q.push_back(op);
            e_mx = oxb; e_my = oyb; last_a = 0; pend_b = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
